// File: rtl/stack_ctrl.sv
// LIFO stack controller for an asynchronous single-port RAM: owns the stack pointer and
// sequences setup/strobe/hold phases for every RAM write and read.
`timescale 1ns/1ps
module stack_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk_i,
  input  logic              RstN_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              ready_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  inout  wire  [DATA_W-1:0] ram_data_io,
  output logic              ram_WEn_o,
  output logic              ram_CSn_o
);

  typedef enum logic [2:0] {
    StIdle, StWrSetup, StWrStrobe, StWrHold, StRdSetup, StRdWait, StRdCap
  } state_e;

  localparam logic [ADDR_W:0]   FullCount = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CountOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] AddrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              r_state, w_state_d;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_err;

  logic w_full, w_empty;
  logic w_push_go, w_pop_go, w_err_d;
  logic w_we, w_cs_n, w_drive;

  assign w_full  = (r_count == FullCount);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_state_d = r_state;
    w_push_go = 1'b0;
    w_pop_go  = 1'b0;
    w_err_d   = 1'b0;
    w_we      = 1'b0;
    w_cs_n    = 1'b1;
    w_drive   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Push has priority; a simultaneous pop is dropped even when the push errors.
        if (push_i) begin
          if (w_full) begin
            w_err_d = 1'b1;
          end else begin
            w_push_go = 1'b1;
            w_state_d = StWrSetup;
          end
        end else if (pop_i) begin
          if (w_empty) begin
            w_err_d = 1'b1;
          end else begin
            w_pop_go  = 1'b1;
            w_state_d = StRdSetup;
          end
        end
      end
      StWrSetup: begin
        w_cs_n    = 1'b0;
        w_drive   = 1'b1;
        w_state_d = StWrStrobe;
      end
      StWrStrobe: begin
        w_cs_n    = 1'b0;
        w_we      = 1'b1;
        w_drive   = 1'b1;
        w_state_d = StWrHold;
      end
      StWrHold: begin
        w_cs_n    = 1'b0;
        w_drive   = 1'b1;
        w_state_d = StIdle;
      end
      StRdSetup: begin
        w_cs_n    = 1'b0;
        w_state_d = StRdWait;
      end
      StRdWait: begin
        w_cs_n    = 1'b0;
        w_state_d = StRdCap;
      end
      StRdCap: begin
        w_cs_n    = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      r_state <= StIdle;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_err_d;
      r_valid <= 1'b0;
      if (w_push_go) begin
        r_wdata <= data_i;
        r_addr  <= r_count[ADDR_W-1:0];
      end
      // Low bits alone give the right top-of-stack address, including at full count.
      if (w_pop_go) begin
        r_addr <= r_count[ADDR_W-1:0] - AddrOne;
      end
      if (r_state == StWrHold) begin
        r_count <= r_count + CountOne;
      end
      if (r_state == StRdCap) begin
        r_data  <= ram_data_io;
        r_count <= r_count - CountOne;
        r_valid <= 1'b1;
      end
    end
  end

  // Strobe and select decode straight from state so they drop the instant reset asserts.
  assign ram_data_io = w_drive ? r_wdata : {DATA_W{1'bz}};
  assign ram_WEn_o   = w_we;
  assign ram_CSn_o   = w_cs_n;
  assign ram_addr_o  = r_addr;
  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign err_o       = r_err;
  assign ready_o     = (r_state == StIdle);
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign count_o     = r_count;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: behavioural RAM plus a queue-based LIFO reference model.
`timescale 1ns/1ps
module tb_stack_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_i = 1'b0;
  logic          pop_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          valid_o, ready_o, full_o, empty_o, err_o;
  logic [AW:0]   count_o;
  logic [AW-1:0] ram_addr_o;
  wire  [DW-1:0] ram_data_io;
  logic          ram_WEn_o, ram_CSn_o;

  stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk_i      (clk),
    .RstN_i     (rst_n),
    .push_i     (push_i),
    .pop_i      (pop_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_o    (ready_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .err_o      (err_o),
    .count_o    (count_o),
    .ram_addr_o (ram_addr_o),
    .ram_data_io(ram_data_io),
    .ram_WEn_o  (ram_WEn_o),
    .ram_CSn_o  (ram_CSn_o)
  );

  always #5 clk = ~clk;

  // RAM model: drives the bus only while a pop is being run and the RAM is selected for read.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          rd_en = 1'b0;
  logic          probe_en = 1'b0;
  logic [DW-1:0] probe_val = '0;
  int            we_cnt = 0;
  int            cs_cnt = 0;

  assign ram_data_io = (rd_en && !ram_CSn_o && !ram_WEn_o) ? mem[ram_addr_o] :
                       (probe_en ? probe_val : {DW{1'bz}});

  always @(posedge ram_WEn_o) begin
    we_cnt <= we_cnt + 1;
    if (!ram_CSn_o) mem[ram_addr_o] <= ram_data_io;
  end

  always @(negedge ram_CSn_o) cs_cnt <= cs_cnt + 1;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data = '0;
  int total = 0;
  int bad = 0;

  // Runs one request through the DUT and checks it against the LIFO model.
  task automatic do_op(input bit p, input bit q, input logic [DW-1:0] d);
    int            n, we0, cs0;
    bit            e_push, e_pop, e_err;
    logic          o_err, o_we_mid;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_bus;
    logic [AW:0]   e_cnt;
    n      = model_q.size();
    e_push = p && (n < DEPTH);
    e_pop  = !p && q && (n > 0);
    e_err  = (p && n == DEPTH) || (!p && q && n == 0);
    @(negedge clk);
    for (int i = 0; i < 8 && ready_o !== 1'b1; i++) @(negedge clk);
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL ready_wait got=%b exp=1", ready_o); end
    we0    = we_cnt;
    cs0    = cs_cnt;
    push_i = p;
    pop_i  = q;
    data_i = d;
    rd_en  = !p;
    @(posedge clk); #1;
    push_i = 1'b0;
    pop_i  = 1'b0;
    data_i = 8'($urandom);
    o_err  = err_o;
    o_addr = ram_addr_o;
    @(posedge clk); #1;
    o_bus    = ram_data_io;
    o_we_mid = ram_WEn_o;
    @(posedge clk);
    @(posedge clk); #1;
    if (e_push) model_q.push_back(d);
    if (e_pop) exp_data = model_q.pop_back();
    e_cnt = (AW+1)'(model_q.size());
    total += 8;
    if (o_err !== e_err) begin bad++; $display("FAIL err got=%b exp=%b", o_err, e_err); end
    if (o_we_mid !== e_push) begin bad++; $display("FAIL we_strobe got=%b exp=%b", o_we_mid, e_push); end
    if (valid_o !== e_pop) begin bad++; $display("FAIL valid got=%b exp=%b", valid_o, e_pop); end
    if (data_o !== exp_data) begin bad++; $display("FAIL data got=%h exp=%h", data_o, exp_data); end
    if (count_o !== e_cnt) begin bad++; $display("FAIL count got=%0d exp=%0d", count_o, e_cnt); end
    if (ready_o !== 1'b1 || ram_CSn_o !== 1'b1) begin
      bad++; $display("FAIL idle_after ready=%b csn=%b exp=1/1", ready_o, ram_CSn_o);
    end
    if (full_o !== (model_q.size() == DEPTH)) begin
      bad++; $display("FAIL full got=%b exp=%b", full_o, model_q.size() == DEPTH);
    end
    if (empty_o !== (model_q.size() == 0)) begin
      bad++; $display("FAIL empty got=%b exp=%b", empty_o, model_q.size() == 0);
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
    total += 4;
    if (err_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL pulse_len err=%b valid=%b exp=0/0", err_o, valid_o);
    end
    if (we_cnt - we0 !== int'(e_push)) begin
      bad++; $display("FAIL we_pulses got=%0d exp=%0d", we_cnt - we0, int'(e_push));
    end
    if (cs_cnt - cs0 !== int'(e_push || e_pop)) begin
      bad++; $display("FAIL cs_accesses got=%0d exp=%0d", cs_cnt - cs0, int'(e_push || e_pop));
    end
    if ((e_push && o_addr !== AW'(n)) || (e_pop && o_addr !== AW'(n - 1))) begin
      bad++; $display("FAIL addr got=%0d exp=%0d", o_addr, e_push ? n : n - 1);
    end
    if (e_push) begin
      total++;
      if (o_bus !== d) begin bad++; $display("FAIL wr_bus got=%h exp=%h", o_bus, d); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total += 3;
    if (count_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      bad++; $display("FAIL rst_count cnt=%0d empty=%b full=%b exp=0/1/0", count_o, empty_o, full_o);
    end
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || err_o !== 1'b0 || data_o !== '0) begin
      bad++; $display("FAIL rst_flags rdy=%b v=%b e=%b d=%h exp=1/0/0/00",
                      ready_o, valid_o, err_o, data_o);
    end
    if (ram_addr_o !== '0 || ram_WEn_o !== 1'b0 || ram_CSn_o !== 1'b1) begin
      bad++; $display("FAIL rst_ram addr=%0d we=%b csn=%b exp=0/0/1", ram_addr_o, ram_WEn_o, ram_CSn_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    probe_en  = 1'b1;
    probe_val = 8'h5A;
    #1;
    total += 3;
    if (ram_data_io !== 8'h5A) begin bad++; $display("FAIL bus_z_5a got=%h exp=5a", ram_data_io); end
    probe_val = 8'hA5;
    #1;
    if (ram_data_io !== 8'hA5) begin bad++; $display("FAIL bus_z_a5 got=%h exp=a5", ram_data_io); end
    probe_en = 1'b0;
    if (ready_o !== 1'b1 || count_o !== '0) begin
      bad++; $display("FAIL post_release rdy=%b cnt=%0d exp=1/0", ready_o, count_o);
    end
  endtask

  task automatic test_basic();
    do_op(1'b1, 1'b0, 8'h11);
    do_op(1'b1, 1'b0, 8'h22);
    do_op(1'b1, 1'b0, 8'h33);
    for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 8'h00);
    total++;
    if (data_o !== 8'h11 || empty_o !== 1'b1) begin
      bad++; $display("FAIL basic_last data=%h empty=%b exp=11/1", data_o, empty_o);
    end
  endtask

  task automatic test_empty_pop();
    do_op(1'b0, 1'b1, 8'h00);
    do_op(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_simultaneous();
    do_op(1'b1, 1'b0, 8'($urandom));
    do_op(1'b1, 1'b0, 8'($urandom));
    do_op(1'b1, 1'b1, 8'hC3);
    total++;
    if (count_o !== 11'd3) begin bad++; $display("FAIL simul_count got=%0d exp=3", count_o); end
    for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_full();
    for (int a = 0; a < DEPTH; a++) do_op(1'b1, 1'b0, 8'(a));
    total++;
    if (full_o !== 1'b1 || count_o !== 11'd1024) begin
      bad++; $display("FAIL full_state full=%b cnt=%0d exp=1/1024", full_o, count_o);
    end
    do_op(1'b1, 1'b0, 8'h5C);
    do_op(1'b1, 1'b1, 8'h5D);
    do_op(1'b0, 1'b1, 8'h00);
    total++;
    if (data_o !== 8'hFF) begin bad++; $display("FAIL full_pop got=%h exp=ff", data_o); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      do_op(r < 4, r >= 3 && r < 9, 8'($urandom));
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    for (int i = 0; i < 8 && ready_o !== 1'b1; i++) @(negedge clk);
    push_i = 1'b1;
    data_i = 8'h9E;
    @(posedge clk); #1;
    push_i = 1'b0;
    @(posedge clk); #1;
    total += 2;
    if (ram_WEn_o !== 1'b1) begin bad++; $display("FAIL midop_strobe got=%b exp=1", ram_WEn_o); end
    rst_n = 1'b0;
    #1;
    if (ram_WEn_o !== 1'b0 || ram_CSn_o !== 1'b1 || count_o !== '0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL midop_rst we=%b csn=%b cnt=%0d rdy=%b exp=0/1/0/1",
                      ram_WEn_o, ram_CSn_o, count_o, ready_o);
    end
    model_q.delete();
    exp_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b1 || empty_o !== 1'b1 || data_o !== '0) begin
      bad++; $display("FAIL midop_release rdy=%b empty=%b d=%h exp=1/1/00", ready_o, empty_o, data_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_pop();
    test_simultaneous();
    test_full();
    test_random();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
